irq_cause_arbiter: RTL and testbench
====================================

# irq_cause_arbiter

Interrupt controller for the interrupt-cause datapath. Collects edge-triggered interrupt requests from up to 31 sources into a pending register and applies a software-writable enable mask. Selects the lowest-numbered enabled pending source and presents it as a single `io_irq` line with a 6-bit cause word: bit 5 = interrupt flag, bits 4:0 = source index. Holds the presented cause until the consumer acknowledges it, then retires that source and arbitrates again.

## Interface
Parameters:
- `N_SRC`, 8, number of interrupt sources (1..31)
- `IDX_W`, 5, width of the source-index field in the cause word (fixed; `N_SRC` ≤ 2^`IDX_W`−1)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `io_src`  in  N_SRC  level request lines; a 0→1 transition raises that source's pending bit
- `io_mask_wen`  in  1  write strobe for the enable mask
- `io_mask_wdata`  in  N_SRC  new mask value; bit i = 1 enables source i
- `io_mask`  out  N_SRC  current enable mask
- `io_pending`  out  N_SRC  current pending bits (unmasked view)
- `io_irq`  out  1  interrupt presented
- `io_irq_cause`  out  6  `{1'b1, idx[4:0]}` while `io_irq`=1; 6'h00 otherwise
- `io_ack`  in  1  consumer acknowledge; sampled only while `io_irq`=1

## Operation
- Edge detect:
  - `src_prev` register samples `io_src` every cycle.
  - `rise = io_src & ~src_prev` sets pending bits.
  - `src_prev` resets to 0, so a source already high when reset deasserts raises pending in the first cycle.
- Mask:
  - `io_mask_wen`=1 loads `io_mask_wdata` on the next edge.
  - Masking never clears pending bits; it only hides them from arbitration.
- State machine `IDLE → PRESENT → HOLDOFF → IDLE`:
  - IDLE: if `pending & mask` ≠ 0, capture `idx` = lowest set bit index into `cause_idx` and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: `io_irq`=1. On `io_ack`=1, clear `pending[cause_idx]` and go to HOLDOFF. Otherwise stay in PRESENT.
  - HOLDOFF: `io_irq`=0. Lasts one cycle, then unconditionally returns to IDLE. This lets the pending clear settle before the next arbitration.
- Pending update per bit and per cycle: `pending_next = (pending & ~clr) | rise`. Set wins over clear when a source re-rises in its own ack cycle.
- In PRESENT, the cause is frozen. Mask writes, new edges and higher-priority arrivals do not change `io_irq_cause` until ack. This holds even if the presented source is masked after capture.
- `io_ack` in IDLE or HOLDOFF has no effect.
- `io_irq_cause` is a registered-state function: `io_irq ? {1'b1, cause_idx} : 6'h00`. Indices above `N_SRC`−1 are never produced.
- Reset (any cycle, including mid-PRESENT):
  - `pending`=0, `mask`=0, `src_prev`=0, `cause_idx`=0, state=IDLE.
  - `io_irq`=0, `io_irq_cause`=6'h00, `io_mask`=0, `io_pending`=0.
  - An unacknowledged interrupt is discarded.

## Timing
- Edge on `io_src[i]` sampled at edge t → `pending[i]`=1 after edge t. IDLE captures at edge t+1 → `io_irq`=1 from edge t+1, assuming mask enabled and IDLE.
- Ack sampled at edge a → `io_irq`=0 and `pending` cleared after edge a (HOLDOFF). IDLE at a+1. Earliest next `io_irq` after edge a+2.
- Maximum throughput: one interrupt per 3 cycles with ack held high.
- Mask write at edge w affects arbitration from the IDLE evaluation after edge w.
- No combinational path from any input to any output.

## Structure
- Shared package `irq_pkg`:
  - `IRQ_IDX_W`=5
  - `IRQ_CAUSE_W`=6
  - `IRQ_FLAG_BIT`=5
  - state encoding `IRQ_IDLE`=2'd0, `IRQ_PRESENT`=2'd1, `IRQ_HOLDOFF`=2'd2
  - these are the values the cause-consuming blocks also use
- One sub-module: `irq_prio_enc`. Combinational lowest-index-first priority encoder, `N_SRC` → `{any, idx[4:0]}`, reusable by other arbiters.

## Test plan
- Reset, then `io_src`=0: `io_irq`=0, `io_irq_cause`=6'h00, `io_mask`=0, `io_pending`=0 for 10 cycles.
- Mask=8'hFF, pulse `io_src[3]` one cycle at t: `io_irq`=1 with cause 6'h23 at t+1. Ack at a: `io_irq`=0 and `io_pending`=0 at a+1. No re-fire.
- Mask=8'hFF, raise `io_src[5]` and `io_src[2]` in the same cycle, ack held high:
  - cause 6'h22 first, then 6'h25 three cycles later, then `io_irq`=0.
  - the later-arriving `io_src[0]` during PRESENT is served third.
- Mask=0, pulse `io_src[1]`: `io_pending`=8'h02 and `io_irq`=0. Write mask 8'h02 at w: `io_irq`=1 with cause 6'h21 after w+1.
- While presenting index 4, re-pulse `io_src[4]` rising in the ack cycle: `pending[4]` stays 1 and cause 6'h24 is presented again after HOLDOFF.
- Assert `reset` for one cycle mid-PRESENT: all outputs 0 next cycle. Ack after reset is ignored. A source held high re-raises pending one cycle after reset deasserts.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared interrupt-cause definitions: cause word layout and arbiter state encoding.
// Cause-consuming blocks import the same constants.
package irq_pkg;

  localparam int IRQ_IDX_W    = 5;
  localparam int IRQ_CAUSE_W  = 6;
  localparam int IRQ_FLAG_BIT = 5;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PRESENT = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_state_e;

  // Builds {flag, idx} so every producer lays the cause word out identically.
  function automatic logic [IRQ_CAUSE_W-1:0] irq_mk_cause(input logic [IRQ_IDX_W-1:0] idx);
    logic [IRQ_CAUSE_W-1:0] c;
    c = '0;
    c[IRQ_FLAG_BIT] = 1'b1;
    c[IRQ_IDX_W-1:0] = idx;
    return c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder: N_SRC requests -> {any, idx}.
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int IDX_W = 5
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the lowest set bit is the last (winning) assignment.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_cause_arbiter.sv
// Edge-triggered interrupt collector with enable mask; presents the lowest enabled
// pending source as a held cause word until acknowledged.
module irq_cause_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int IDX_W = IRQ_IDX_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       io_src,
  input  logic                   io_mask_wen,
  input  logic [N_SRC-1:0]       io_mask_wdata,
  output logic [N_SRC-1:0]       io_mask,
  output logic [N_SRC-1:0]       io_pending,
  output logic                   io_irq,
  output logic [IRQ_CAUSE_W-1:0] io_irq_cause,
  input  logic                   io_ack
);

  logic [N_SRC-1:0] src_prev, pending, mask;
  logic [N_SRC-1:0] rise, clr, arb_req;
  logic [IDX_W-1:0] cause_idx, enc_idx;
  logic             enc_any, capture, retire;
  irq_state_e       state, state_nxt;

  assign rise    = io_src & ~src_prev;
  assign arb_req = pending & mask;
  assign clr     = retire ? (N_SRC'(1) << cause_idx) : '0;

  irq_prio_enc #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_enc (
    .req (arb_req),
    .any (enc_any),
    .idx (enc_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IRQ_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (enc_any) begin
          capture   = 1'b1;
          state_nxt = IRQ_PRESENT;
        end
      end
      IRQ_PRESENT: begin
        if (io_ack) begin
          retire    = 1'b1;
          state_nxt = IRQ_HOLDOFF;
        end
      end
      // One dead cycle so the retired pending bit is gone before re-arbitration.
      IRQ_HOLDOFF: state_nxt = IRQ_IDLE;
      default:     state_nxt = IRQ_IDLE;
    endcase
  end

  // Set wins over clear: a source re-rising in its own ack cycle stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_prev  <= '0;
      pending   <= '0;
      mask      <= '0;
      cause_idx <= '0;
    end else begin
      src_prev <= io_src;
      pending  <= (pending & ~clr) | rise;
      if (io_mask_wen) mask      <= io_mask_wdata;
      if (capture)     cause_idx <= enc_idx;
    end
  end

  assign io_mask      = mask;
  assign io_pending   = pending;
  assign io_irq       = (state == IRQ_PRESENT);
  assign io_irq_cause = io_irq ? irq_mk_cause(cause_idx) : '0;

endmodule

// File: tb/tb_irq_cause_arbiter.sv
// Directed table-driven bench for irq_cause_arbiter (N_SRC=8), plus hand-written
// reset-mid-present and bounded-wait sequences.
module tb_irq_cause_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] io_src, io_mask_wdata, io_mask, io_pending;
  logic       io_mask_wen, io_irq, io_ack;
  logic [5:0] io_irq_cause;

  int n_cmp = 0;
  int n_err = 0;

  irq_cause_arbiter #(.N_SRC(8), .IDX_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_src        (io_src),
    .io_mask_wen   (io_mask_wen),
    .io_mask_wdata (io_mask_wdata),
    .io_mask       (io_mask),
    .io_pending    (io_pending),
    .io_irq        (io_irq),
    .io_irq_cause  (io_irq_cause),
    .io_ack        (io_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] src;
    logic       wen;
    logic [7:0] wd;
    logic       ack;
    logic       irq;
    logic [5:0] cause;
    logic [7:0] pend;
    logic [7:0] mask;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic [7:0] src, input logic wen,
                              input logic [7:0] wd, input logic ack, input logic irq,
                              input logic [5:0] cause, input logic [7:0] pend,
                              input logic [7:0] mask);
    vec_t v;
    v.rst = rst; v.src = src; v.wen = wen; v.wd = wd; v.ack = ack;
    v.irq = irq; v.cause = cause; v.pend = pend; v.mask = mask;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] src, input logic wen,
                       input logic [7:0] wd, input logic ack);
    reset = rst; io_src = src; io_mask_wen = wen; io_mask_wdata = wd; io_ack = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int row, input logic irq, input logic [5:0] cause,
                           input logic [7:0] pend, input logic [7:0] mask);
    check("irq",     row, 32'(io_irq),       32'(irq));
    check("cause",   row, 32'(io_irq_cause), 32'(cause));
    check("pending", row, 32'(io_pending),   32'(pend));
    check("mask",    row, 32'(io_mask),      32'(mask));
  endtask

  initial begin
    bit seen;
    drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);

    // Each row: inputs before an edge, expected outputs after it.
    //  rst src   wen wd    ack  irq cause  pend   mask
    add(1, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) add(0, 8'h00, 0, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00);
    // single pulse on src[3], serve, no re-fire
    add(0, 8'h00, 1, 8'hFF, 0,   0, 6'h00, 8'h00, 8'hFF);
    add(0, 8'h08, 0, 8'h00, 0,   0, 6'h00, 8'h08, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   1, 6'h23, 8'h08, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   1, 6'h23, 8'h08, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 1,   0, 6'h00, 8'h00, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h00, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h00, 8'hFF);
    // src[5] and src[2] together, ack held; src[0] rises while 0x25 presented
    add(0, 8'h24, 0, 8'h00, 1,   0, 6'h00, 8'h24, 8'hFF);
    add(0, 8'h24, 0, 8'h00, 1,   1, 6'h22, 8'h24, 8'hFF);
    add(0, 8'h24, 0, 8'h00, 1,   0, 6'h00, 8'h20, 8'hFF);
    add(0, 8'h24, 0, 8'h00, 1,   0, 6'h00, 8'h20, 8'hFF);
    add(0, 8'h24, 0, 8'h00, 1,   1, 6'h25, 8'h20, 8'hFF);
    add(0, 8'h25, 0, 8'h00, 1,   0, 6'h00, 8'h01, 8'hFF);
    add(0, 8'h24, 0, 8'h00, 1,   0, 6'h00, 8'h01, 8'hFF);
    add(0, 8'h24, 0, 8'h00, 1,   1, 6'h20, 8'h01, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 1,   0, 6'h00, 8'h00, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h00, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h00, 8'hFF);
    // masked pending, then enable via mask write
    add(0, 8'h00, 1, 8'h00, 0,   0, 6'h00, 8'h00, 8'h00);
    add(0, 8'h02, 0, 8'h00, 0,   0, 6'h00, 8'h02, 8'h00);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h02, 8'h00);
    add(0, 8'h00, 0, 8'h00, 1,   0, 6'h00, 8'h02, 8'h00);
    add(0, 8'h00, 1, 8'h02, 0,   0, 6'h00, 8'h02, 8'h02);
    add(0, 8'h00, 0, 8'h00, 0,   1, 6'h21, 8'h02, 8'h02);
    add(0, 8'h00, 0, 8'h00, 1,   0, 6'h00, 8'h00, 8'h02);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h00, 8'h02);
    // src[4] re-rises in its own ack cycle: set wins, presented again
    add(0, 8'h00, 1, 8'hFF, 0,   0, 6'h00, 8'h00, 8'hFF);
    add(0, 8'h10, 0, 8'h00, 0,   0, 6'h00, 8'h10, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   1, 6'h24, 8'h10, 8'hFF);
    add(0, 8'h10, 0, 8'h00, 1,   0, 6'h00, 8'h10, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h10, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   1, 6'h24, 8'h10, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 1,   0, 6'h00, 8'h00, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h00, 8'hFF);
    // cause frozen across masking of itself and a higher-priority arrival
    add(0, 8'h10, 0, 8'h00, 0,   0, 6'h00, 8'h10, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0,   1, 6'h24, 8'h10, 8'hFF);
    add(0, 8'h02, 1, 8'hEF, 0,   1, 6'h24, 8'h12, 8'hEF);
    add(0, 8'h00, 0, 8'h00, 0,   1, 6'h24, 8'h12, 8'hEF);
    add(0, 8'h00, 0, 8'h00, 1,   0, 6'h00, 8'h02, 8'hEF);
    add(0, 8'h00, 0, 8'h00, 0,   0, 6'h00, 8'h02, 8'hEF);
    add(0, 8'h00, 0, 8'h00, 0,   1, 6'h21, 8'h02, 8'hEF);

    foreach (tbl[r]) begin
      drive(tbl[r].rst, tbl[r].src, tbl[r].wen, tbl[r].wd, tbl[r].ack);
      step();
      check_all(r, tbl[r].irq, tbl[r].cause, tbl[r].pend, tbl[r].mask);
    end

    // Reset while presenting 0x21, src[3] held high throughout.
    drive(1'b1, 8'h08, 1'b0, 8'h00, 1'b0);
    step();
    check_all(1000, 1'b0, 6'h00, 8'h00, 8'h00);
    drive(1'b0, 8'h08, 1'b0, 8'h00, 1'b1);
    step();
    check_all(1001, 1'b0, 6'h00, 8'h08, 8'h00);
    step();
    check_all(1002, 1'b0, 6'h00, 8'h08, 8'h00);

    // Enable everything and wait (bounded) for the held source to be presented.
    drive(1'b0, 8'h08, 1'b1, 8'hFF, 1'b0);
    step();
    io_mask_wen = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      step();
      seen = io_irq;
    end
    check("irq_wait", 1003, 32'(seen), 32'd1);
    check("cause_after_reset", 1004, 32'(io_irq_cause), 32'h23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
